// File: rtl/wallace_col_gather_pkg.sv
// Shared constants and index helpers for the column-to-row gather stage.
// Fixes the partial-product geometry and the bit-slicing used on both bus sides.
package wallace_col_gather_pkg;

  localparam int ROWS          = 17;
  localparam int COLS          = 68;
  localparam int COLS_PER_BEAT = 4;
  localparam int BEATS         = COLS / COLS_PER_BEAT;
  localparam int CNT_W         = $clog2(BEATS);
  localparam int BEAT_W        = ROWS * COLS_PER_BEAT;
  localparam int FRAME_W       = ROWS * COLS;

  typedef logic [0:0] state_t;

  localparam state_t ST_FILL = 1'b0;
  localparam state_t ST_FULL = 1'b1;

  // Bit position of row r inside local column k of an input beat.
  function automatic int col_bit_idx(input int k, input int r);
    return k * ROWS + r;
  endfunction

  // Bit position of global column c inside row r of the assembled frame.
  function automatic int row_bit_idx(input int r, input int c);
    return r * COLS + c;
  endfunction

endpackage

// File: rtl/wallace_col_gather_if.sv
// Beat-in / frame-out handshake bundle for wallace_col_gather.
// master = producer/consumer side (bench or neighbours), slave = the gather block.
interface wallace_col_gather_if;
  import wallace_col_gather_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BEAT_W-1:0]  in_cols;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [FRAME_W-1:0] out_rows;

  modport master (
    output in_valid, in_cols, in_last, out_ready,
    input  in_ready, out_valid, out_rows
  );

  modport slave (
    input  in_valid, in_cols, in_last, out_ready,
    output in_ready, out_valid, out_rows
  );

endinterface

// File: rtl/wallace_col_gather.sv
// Reassembles column-serial beats (COLS_PER_BEAT columns of ROWS bits each)
// into a row-major ROWS x COLS frame and hands it out with valid/ready.
module wallace_col_gather
  import wallace_col_gather_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  wallace_col_gather_if.slave  bus,
  output logic                 frame_err
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [FRAME_W-1:0] r_buf;
  logic               r_frame_err;

  logic               w_acc;
  logic               w_out_hs;
  logic               w_last_pos;
  logic               w_frame_done;
  logic               w_misalign;
  logic [BEATS-1:0]   w_beat_we;

  // In FULL the next frame's first beat may only enter alongside the output handshake.
  assign bus.in_ready  = (r_state == ST_FILL) ? 1'b1 : bus.out_ready;
  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_rows  = r_buf;
  assign frame_err     = r_frame_err;

  assign w_acc        = bus.in_valid && bus.in_ready && !flush;
  assign w_out_hs     = bus.out_valid && bus.out_ready && !flush;
  assign w_last_pos   = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_frame_done = w_acc && bus.in_last && w_last_pos;
  assign w_misalign   = w_acc && (bus.in_last != w_last_pos);

  for (genvar b = 0; b < BEATS; b++) begin : g_beat_we
    assign w_beat_we[b] = w_acc && (r_beat_cnt == CNT_W'(b));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_FILL;
      r_beat_cnt  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      // NOTE: non-blocking default followed by overrides; the last assignment wins, so the pulse self-clears.
      r_frame_err <= 1'b0;
      if (flush) begin
        r_state    <= ST_FILL;
        r_beat_cnt <= '0;
      end else if (w_acc) begin
        if (w_frame_done) begin
          r_state    <= ST_FULL;
          r_beat_cnt <= '0;
        end else if (w_misalign) begin
          r_state     <= ST_FILL;
          r_beat_cnt  <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_state    <= ST_FILL;
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
      end else if (w_out_hs) begin
        r_state    <= ST_FILL;
        r_beat_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the frame buffer is reset deliberately so out_rows reads zero out of reset.
      r_buf <= '0;
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        if (w_beat_we[b]) begin
          for (int k = 0; k < COLS_PER_BEAT; k++) begin
            for (int r = 0; r < ROWS; r++) begin
              r_buf[row_bit_idx(r, b * COLS_PER_BEAT + k)] <= bus.in_cols[col_bit_idx(k, r)];
            end
          end
        end
      end
    end
  end

endmodule
